// File: rtl/osd_trace_packetizer.sv
// osd_trace_packetizer: pops trace samples or overflow records from the trace FIFO
// and serializes each into a 16-bit debug packet (dest, src, type, payload).
module osd_trace_packetizer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      id,
    input  logic [15:0]      dest,
    input  logic [WIDTH-1:0] trace_data,
    input  logic             trace_overflow,
    input  logic             trace_valid,
    output logic             trace_ready,
    output logic [15:0]      debug_out_data,
    output logic             debug_out_last,
    output logic             debug_out_valid,
    input  logic             debug_out_ready
);
    localparam int NFLITS = WIDTH / 16;
    localparam int IW = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NFLITS - 1);

    typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [15:0]      payload;
    logic             xfer;

    assign payload     = 16'(data_q >> {idx_q, 4'h0});
    assign xfer        = debug_out_valid & debug_out_ready;
    assign trace_ready = (state_q == IDLE) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        data_d          = data_q;
        ovf_d           = ovf_q;
        idx_d           = idx_q;
        debug_out_valid = state_q != IDLE;
        debug_out_data  = '0;
        debug_out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (trace_valid) begin
                    data_d  = trace_data;
                    ovf_d   = trace_overflow;
                    idx_d   = '0;
                    state_d = DEST;
                end
            end
            DEST: begin
                debug_out_data = dest;
                state_d        = xfer ? SRC : DEST;
            end
            SRC: begin
                debug_out_data = id;
                state_d        = xfer ? TYPE : SRC;
            end
            TYPE: begin
                debug_out_data = ovf_q ? 16'h8400 : 16'h8000;
                state_d        = xfer ? PAYLOAD : TYPE;
            end
            PAYLOAD: begin
                // overflow records carry only the 16-bit count, so they end after one flit
                debug_out_data = payload;
                debug_out_last = ovf_q | (idx_q == LAST_IDX);
                if (xfer) begin
                    if (debug_out_last) state_d = IDLE;
                    else idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
